// File: rtl/mem_port_arbiter.sv
// Purpose : shares the CPU's single 32-bit memory port between master 0
//           (fetch/load/store) and master 1 (loader/DMA). Arbitration is
//           round-robin or fixed priority with a starvation guard for master 1.
// Latency : grant is combinational in the request cycle; read data returns
//           one cycle after the grant, flagged by the owner's rvalid.
// Backpressure: a master holds req/addr/wdata/wstrb until it sees gnt. It may
//           drop req before being granted, and that has no side effect.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mX_req/addr/wdata/wstrb (in)    master X request; wstrb == 0 is a read
//   mX_gnt (out)                    transfer accepted this cycle
//   mX_rvalid/rdata (out)           read data for master X (rdata = mem_rdata)
//   mem_addr/wdata/wenable (out)    memory port, driven by the granted master
//   mem_rdata (in)                  memory read data, one cycle after address
module mem_port_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 8,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wenable,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q,   rd_owner_d;

  logic gnt0_raw, gnt1_raw;
  logic starve_hit;
  logic accept;
  logic accept_rd;

  // Master 1 is forced through once it has been denied STARVE_LIMIT times in a row.
  assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt_q == LIMIT) && m1_req;

  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    if (PRIORITY_MODE == 0) begin
      if (m0_req && m1_req) begin
        // Tie goes to whoever did not own the port last.
        gnt0_raw = last_owner_q;
        gnt1_raw = !last_owner_q;
      end else begin
        gnt0_raw = m0_req;
        gnt1_raw = m1_req;
      end
    end else begin
      if (starve_hit) begin
        gnt1_raw = 1'b1;
      end else if (m0_req) begin
        gnt0_raw = 1'b1;
      end else if (m1_req) begin
        gnt1_raw = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held so no write can reach memory.
  assign m0_gnt = gnt0_raw && rst_n;
  assign m1_gnt = gnt1_raw && rst_n;

  always_comb begin
    mem_addr    = m0_addr;
    mem_wdata   = m0_wdata;
    mem_wenable = 4'b0000;
    if (m1_gnt) begin
      mem_addr    = m1_addr;
      mem_wdata   = m1_wdata;
      mem_wenable = m1_wstrb;
    end else if (m0_gnt) begin
      mem_wenable = m0_wstrb;
    end
  end

  assign accept    = m0_gnt || m1_gnt;
  assign accept_rd = accept && (mem_wenable == 4'b0000);

  always_comb begin
    last_owner_d = accept ? m1_gnt : last_owner_q;

    starve_cnt_d = starve_cnt_q;
    if (!m1_req || m1_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    // Only a read leaves a one-cycle pending slot; every other edge clears it.
    rd_pending_d = accept_rd;
    rd_owner_d   = accept_rd ? m1_gnt : rd_owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b1;
      starve_cnt_q <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign m0_rvalid = rd_pending_q && !rd_owner_q;
  assign m1_rvalid = rd_pending_q &&  rd_owner_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int FX_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic [1:0]  g0, g1, rv0, rv1;
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];
  logic [3:0]  mwen [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance.
  int last_o [2];
  int denied [2];
  int pend   [2];
  string nm [2] = '{"rr", "fx"};

  always #5 clk = ~clk;

  mem_port_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(8), .CNT_W(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_wenable(mwen[0]),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(FX_LIMIT), .CNT_W(4)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_wenable(mwen[1]),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      last_o[k] = 1;
      denied[k] = 0;
      pend[k]   = -1;
    end
  endfunction

  // Which master should own the port this cycle (-1 = none).
  function automatic int winner(int k);
    if (!rst_n) return -1;
    if (k == 0) begin
      if (m0_req && m1_req) return 1 - last_o[k];
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
    end
    if (m1_req && denied[k] == FX_LIMIT) return 1;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  // Called just after a falling edge with inputs applied: check, then advance one clock.
  task automatic tick();
    int w [2];
    logic [3:0] exp_wen;
    if (!rst_n) model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      w[k] = winner(k);
      exp_wen = (w[k] == 0) ? m0_wstrb : (w[k] == 1) ? m1_wstrb : 4'b0000;
      chk({nm[k], ".m0_gnt"}, 32'(g0[k]), 32'(w[k] == 0));
      chk({nm[k], ".m1_gnt"}, 32'(g1[k]), 32'(w[k] == 1));
      chk({nm[k], ".mem_addr"}, maddr[k], (w[k] == 1) ? m1_addr : m0_addr);
      chk({nm[k], ".mem_wdata"}, mwdata[k], (w[k] == 1) ? m1_wdata : m0_wdata);
      chk({nm[k], ".mem_wenable"}, 32'(mwen[k]), 32'(exp_wen));
      chk({nm[k], ".m0_rvalid"}, 32'(rv0[k]), 32'(pend[k] == 0));
      chk({nm[k], ".m1_rvalid"}, 32'(rv1[k]), 32'(pend[k] == 1));
      chk({nm[k], ".m0_rdata"}, rd0[k], mem_rdata);
      chk({nm[k], ".m1_rdata"}, rd1[k], mem_rdata);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m1_req && w[k] != 1) denied[k] = (denied[k] < FX_LIMIT) ? denied[k] + 1 : FX_LIMIT;
        else denied[k] = 0;
        pend[k] = -1;
        if (w[k] >= 0) begin
          last_o[k] = w[k];
          if (((w[k] == 0) ? m0_wstrb : m1_wstrb) == 4'b0000) pend[k] = w[k];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input logic r0, input logic r1);
    m0_req = r0;
    m1_req = r1;
    m0_addr = $urandom;
    m1_addr = $urandom;
    m0_wdata = $urandom;
    m1_wdata = $urandom;
    m0_wstrb = 4'b0000;
    m1_wstrb = 4'b0000;
    mem_rdata = $urandom;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1; m0_wstrb = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h2; m1_wstrb = 4'hF;
    mem_rdata = 32'h0;
    @(negedge clk);
    // Requests while in reset: no grant, no write.
    tick();
    tick();

    // Single m0 read, data returns next cycle.
    rst_n = 1'b1;
    set_req(1'b1, 1'b0);
    m0_addr = 32'h100;
    tick();
    set_req(1'b0, 1'b0);
    mem_rdata = 32'hDEADBEEF;
    tick();

    // Both masters reading continuously: alternation (rr) and starvation guard (fx).
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 1'b1);
      tick();
    end
    set_req(1'b0, 1'b0);
    tick();

    // Lone m1 write.
    set_req(1'b0, 1'b1);
    m1_addr = 32'h20; m1_wdata = 32'h1234ABCD; m1_wstrb = 4'b0011;
    tick();
    set_req(1'b0, 1'b0);
    tick();
    tick();

    // Reset pulsed right after an accepted m0 read.
    set_req(1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    set_req(1'b1, 1'b1);
    tick();
    set_req(1'b0, 1'b0);
    tick();

    // m1 requests, gives up, then requests again while m0 hogs the port.
    for (int i = 0; i < 9; i++) begin
      set_req(1'b1, (i < 2) || (i > 2));
      tick();
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      m0_req = ($urandom_range(0, 99) < 65);
      m1_req = ($urandom_range(0, 99) < 65);
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_wstrb = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
      m1_wstrb = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
      mem_rdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
